alu_arbiter: RTL

//  Shares one ALU instance (ADD=4'b0000, OR=4'b0001, other codes -> result 0) between two

---
 rtl/alu_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit ALU between two requesters with round-robin
// arbitration. Requests and responses use valid/ready handshakes. Only one
// operation is in flight at a time. Operands and the result are registered.
//
// Ports
//   clk, reset                   rising-edge clock, synchronous active-low reset
//   req_valid_N_i/req_ready_N_o  request handshake, requester N (0 = core, 1 = aux)
//   req_op_N_i                   ALU operation code, requester N
//   req_a_N_i/req_b_N_i          operands, requester N
//   resp_valid_N_o/resp_ready_N_i response handshake, requester N
//   resp_result_N_o              ALU result (0 unless requester N owns the response)
//   resp_zero_N_o                ALU zero flag (0 unless requester N owns the response)
//   busy_o                       high whenever the arbiter is not idle
//   owner_o                      requester owning the in-flight operation

// alu32: combinational ALU. ADD and OR are supported; every other code
// produces a result of 0. The zero flag is high when the result is 0.
module alu32 #(
  parameter int unsigned OP_WIDTH = 4
) (
  input  logic [OP_WIDTH-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic [31:0]         result,
  output logic                zero
);

  localparam logic [OP_WIDTH-1:0] OP_ADD = '0;
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(1);

  always_comb begin
    result = '0;
    if (op == OP_ADD) begin
      result = a + b;
    end else if (op == OP_OR) begin
      result = a | b;
    end
    zero = (result == '0);
  end

endmodule

module alu_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4,
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req_valid_0_i,
  output logic                  req_ready_0_o,
  input  logic [OP_WIDTH-1:0]   req_op_0_i,
  input  logic [DATA_WIDTH-1:0] req_a_0_i,
  input  logic [DATA_WIDTH-1:0] req_b_0_i,

  input  logic                  req_valid_1_i,
  output logic                  req_ready_1_o,
  input  logic [OP_WIDTH-1:0]   req_op_1_i,
  input  logic [DATA_WIDTH-1:0] req_a_1_i,
  input  logic [DATA_WIDTH-1:0] req_b_1_i,

  output logic                  resp_valid_0_o,
  input  logic                  resp_ready_0_i,
  output logic [DATA_WIDTH-1:0] resp_result_0_o,
  output logic                  resp_zero_0_o,

  output logic                  resp_valid_1_o,
  input  logic                  resp_ready_1_i,
  output logic [DATA_WIDTH-1:0] resp_result_1_o,
  output logic                  resp_zero_1_o,

  output logic                  busy_o,
  output logic                  owner_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic                    prio;
  logic                    owner;
  logic                    busy;
  logic                    resp_valid_0;
  logic                    resp_valid_1;
  logic [OP_WIDTH-1:0]     op_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [DATA_WIDTH-1:0]   result_q;
  logic                    zero_q;

  logic                    grant_0;
  logic                    grant_1;
  logic [31:0]             alu_result;
  logic                    alu_zero;
  logic                    owner_ready;

  alu32 #(
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Grants are only offered in IDLE. They are also masked while reset is
  // held, so no requester sees a ready that cannot be honoured.
  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (reset && (state == IDLE)) begin
      if (req_valid_0_i && req_valid_1_i) begin
        grant_0 = ~prio;
        grant_1 = prio;
      end else begin
        grant_0 = req_valid_0_i;
        grant_1 = req_valid_1_i;
      end
    end
  end

  always_comb begin
    owner_ready = owner ? resp_ready_1_i : resp_ready_0_i;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      prio         <= 1'(PRIO_RESET);
      owner        <= 1'b0;
      busy         <= 1'b0;
      resp_valid_0 <= 1'b0;
      resp_valid_1 <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_0 || grant_1) begin
            op_q  <= grant_1 ? req_op_1_i : req_op_0_i;
            a_q   <= grant_1 ? req_a_1_i  : req_a_0_i;
            b_q   <= grant_1 ? req_b_1_i  : req_b_0_i;
            owner <= grant_1;
            prio  <= ~grant_1;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= alu_result;
          zero_q       <= alu_zero;
          resp_valid_0 <= ~owner;
          resp_valid_1 <= owner;
          state        <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            resp_valid_0 <= 1'b0;
            resp_valid_1 <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          resp_valid_0 <= 1'b0;
          resp_valid_1 <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_0_o   = grant_0;
  assign req_ready_1_o   = grant_1;
  assign resp_valid_0_o  = resp_valid_0;
  assign resp_valid_1_o  = resp_valid_1;
  assign resp_result_0_o = resp_valid_0 ? result_q : '0;
  assign resp_result_1_o = resp_valid_1 ? result_q : '0;
  assign resp_zero_0_o   = resp_valid_0 & zero_q;
  assign resp_zero_1_o   = resp_valid_1 & zero_q;
  assign busy_o          = busy;
  assign owner_o         = owner;

endmodule
